// File: rtl/border_hit_scheduler_if.sv
// Report handshake between the border hit scheduler and the physics unit.
// The scheduler drives the report, and the physics unit answers with hitAck.
interface border_hit_scheduler_if #(
  parameter int NUM_BALLS = 8
);
  localparam int BALL_W = $clog2(NUM_BALLS);

  logic              hitValid;
  logic [BALL_W-1:0] hitBall;
  logic [1:0]        hitSide;
  logic              hitAck;

  modport master (output hitValid, hitBall, hitSide, input hitAck);
  modport slave  (input hitValid, hitBall, hitSide, output hitAck);
endinterface

// File: rtl/border_hit_scheduler.sv
// Collects ball-versus-border overlaps over one frame. At each frame boundary
// it snapshots them, then hands one report per ball to the physics unit,
// granting the balls in round-robin order.
//
// state   | meaning
// IDLE    | nothing presented; a non-empty snapshot is loaded on arrival
// PRESENT | hitValid=1; hitBall/hitSide held until acked or a frame boundary
module border_hit_scheduler #(
  parameter  int NUM_BALLS    = 8,
  parameter  int TOP_OFFSET   = 0,
  parameter  int DOWN_OFFSET  = 479,
  parameter  int LEFT_OFFSET  = 0,
  parameter  int RIGHT_OFFSET = 639,
  localparam int BALL_W       = $clog2(NUM_BALLS)
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  startOfFrame,
  input  logic signed [10:0]    pixelX,
  input  logic signed [10:0]    pixelY,
  input  logic                  drawingRequestBorders,
  input  logic [NUM_BALLS-1:0]  drawingRequestBalls,
  output logic                  overrun,
  border_hit_scheduler_if.master hit
);

  // Reject parameter sets that make the playfield or the ball index meaningless.
  if (NUM_BALLS < 2 || NUM_BALLS > 16 ||
      RIGHT_OFFSET < LEFT_OFFSET || DOWN_OFFSET < TOP_OFFSET) begin : g_bad_params
    $error("border_hit_scheduler: illegal parameter set");
  end

  localparam logic signed [10:0] TOP_S  = TOP_OFFSET[10:0];
  localparam logic signed [10:0] DOWN_S = DOWN_OFFSET[10:0];
  localparam logic signed [10:0] LEFT_S = LEFT_OFFSET[10:0];
  localparam logic [BALL_W-1:0]  LAST   = BALL_W'(NUM_BALLS - 1);

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  state_t                state_q, state_d;
  logic signed [10:0]    px_d, py_d;
  logic [1:0]            side_now;
  logic [NUM_BALLS-1:0]  hit_now;
  logic [NUM_BALLS-1:0]  cap_pend, rep_pend, rep_pend_d;
  logic [1:0]            cap_side [NUM_BALLS];
  logic [1:0]            rep_side [NUM_BALLS];
  logic [NUM_BALLS-1:0]  pend_base, pend_src;
  logic [BALL_W-1:0]     rr_ptr, rr_ptr_d, ptr_start;
  logic [BALL_W-1:0]     ball_q, ball_d, win;
  logic [1:0]            side_q, side_d;
  logic                  overrun_d, ack_ok, found;
  int                    idx;

  // Delay the pixel coordinates so they line up with the registered requests.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      px_d <= '0;
      py_d <= '0;
    end else begin
      px_d <= pixelX;
      py_d <= pixelY;
    end
  end

  // Classify which wall the delayed pixel belongs to; corners go top, bottom, left.
  always_comb begin
    side_now = 2'd3;
    if (py_d < TOP_S)       side_now = 2'd0;
    else if (py_d > DOWN_S) side_now = 2'd1;
    else if (px_d < LEFT_S) side_now = 2'd2;
    hit_now = drawingRequestBalls & {NUM_BALLS{drawingRequestBorders}};
  end

  // Capture the first overlap of each ball per frame. A frame boundary starts
  // a fresh set that already includes overlaps seen on that same cycle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cap_pend <= '0;
      for (int i = 0; i < NUM_BALLS; i++) cap_side[i] <= 2'd0;
    end else begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        if (startOfFrame) begin
          cap_pend[i] <= hit_now[i];
          if (hit_now[i]) cap_side[i] <= side_now;
        end else if (hit_now[i] && !cap_pend[i]) begin
          cap_pend[i] <= 1'b1;
          cap_side[i] <= side_now;
        end
      end
    end
  end

  // Snapshot the wall sides alongside the pending bits at each frame boundary.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_BALLS; i++) rep_side[i] <= 2'd0;
    end else if (startOfFrame) begin
      rep_side <= cap_side;
    end
  end

  // Next-state and next-report: retire the acked report, take a new snapshot
  // on a frame boundary, and pick the round-robin winner for the next cycle.
  always_comb begin
    ack_ok    = (state_q == PRESENT) && hit.hitAck;
    ptr_start = rr_ptr;
    pend_base = rep_pend;
    if (ack_ok) begin
      ptr_start         = (ball_q == LAST) ? '0 : ball_q + BALL_W'(1);
      pend_base[ball_q] = 1'b0;
    end

    overrun_d = 1'b0;
    pend_src  = pend_base;
    if (startOfFrame) begin
      overrun_d = |pend_base;
      pend_src  = cap_pend;
    end

    found = 1'b0;
    win   = ptr_start;
    idx   = 0;
    for (int k = 0; k < NUM_BALLS; k++) begin
      idx = int'(ptr_start) + k;
      if (idx >= NUM_BALLS) idx = idx - NUM_BALLS;
      if (!found && pend_src[BALL_W'(idx)]) begin
        found = 1'b1;
        win   = BALL_W'(idx);
      end
    end

    state_d    = state_q;
    ball_d     = ball_q;
    side_d     = side_q;
    rr_ptr_d   = ptr_start;
    rep_pend_d = pend_src;
    if (state_q == IDLE || ack_ok || startOfFrame) begin
      if (found) begin
        state_d = PRESENT;
        ball_d  = win;
        side_d  = startOfFrame ? cap_side[win] : rep_side[win];
      end else begin
        state_d = IDLE;
      end
    end
  end

  // State register together with the registered report outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      rep_pend <= '0;
      rr_ptr   <= '0;
      ball_q   <= '0;
      side_q   <= 2'd0;
      overrun  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rep_pend <= rep_pend_d;
      rr_ptr   <= rr_ptr_d;
      ball_q   <= ball_d;
      side_q   <= side_d;
      overrun  <= overrun_d;
    end
  end

  assign hit.hitValid = (state_q == PRESENT);
  assign hit.hitBall  = ball_q;
  assign hit.hitSide  = side_q;

endmodule

// File: tb/tb_border_hit_scheduler.sv
// Bench for border_hit_scheduler: directed scenarios plus a randomized run,
// both compared cycle by cycle against a frame-level reference model.
module tb_border_hit_scheduler;
  localparam int N = 8;

  logic                clk = 1'b0;
  logic                resetN;
  logic                startOfFrame;
  logic signed [10:0]  pixelX, pixelY;
  logic                drawingRequestBorders;
  logic [N-1:0]        drawingRequestBalls;
  logic                overrun;

  border_hit_scheduler_if #(.NUM_BALLS(N)) hit ();

  border_hit_scheduler #(.NUM_BALLS(N)) dut (
    .clk                   (clk),
    .resetN                (resetN),
    .startOfFrame          (startOfFrame),
    .pixelX                (pixelX),
    .pixelY                (pixelY),
    .drawingRequestBorders (drawingRequestBorders),
    .drawingRequestBalls   (drawingRequestBalls),
    .overrun               (overrun),
    .hit                   (hit)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: this frame's first hits, the report set being delivered,
  // the round-robin pointer and the report currently offered.
  bit m_cap [N];
  int m_cap_side [N];
  bit m_rep [N];
  int m_rep_side [N];
  int m_rr;
  bit m_valid;
  int m_ball, m_side;
  bit m_ov;
  int m_xd, m_yd;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int side_of(input int x, input int y);
    if (y < 0)   return 0;
    if (y > 479) return 1;
    if (x < 0)   return 2;
    return 3;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cap[i] = 0; m_cap_side[i] = 0; m_rep[i] = 0; m_rep_side[i] = 0;
    end
    m_rr = 0; m_valid = 0; m_ball = 0; m_side = 0; m_ov = 0; m_xd = 0; m_yd = 0;
  endtask

  task automatic model_step(input bit sof, input int x, input int y,
                            input bit bord, input logic [N-1:0] balls, input bit ack);
    bit acked;
    bit reselect;
    acked    = m_valid && ack;
    reselect = !m_valid || acked || sof;
    m_ov = 0;
    if (acked) begin
      m_rep[m_ball] = 0;
      m_rr = (m_ball + 1) % N;
    end
    if (sof) begin
      for (int i = 0; i < N; i++) if (m_rep[i]) m_ov = 1;
      for (int i = 0; i < N; i++) begin
        m_rep[i] = m_cap[i]; m_rep_side[i] = m_cap_side[i]; m_cap[i] = 0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (bord && balls[i] && !m_cap[i]) begin
        m_cap[i] = 1;
        m_cap_side[i] = side_of(m_xd, m_yd);
      end
    end
    if (reselect) begin
      m_valid = 0;
      for (int k = 0; k < N; k++) begin
        if (!m_valid && m_rep[(m_rr + k) % N]) begin
          m_valid = 1;
          m_ball  = (m_rr + k) % N;
          m_side  = m_rep_side[m_ball];
        end
      end
    end
    m_xd = x;
    m_yd = y;
  endtask

  task automatic compare_all();
    chk("valid", int'(hit.hitValid), int'(m_valid));
    chk("overrun", int'(overrun), int'(m_ov));
    if (m_valid) begin
      chk("ball", int'(hit.hitBall), m_ball);
      chk("side", int'(hit.hitSide), m_side);
    end
  endtask

  // Drive one cycle of inputs, advance the model, and compare just after the edge.
  task automatic cyc(input bit sof, input int x, input int y, input bit bord,
                     input logic [N-1:0] balls, input bit ack);
    startOfFrame          = sof;
    pixelX                = x[10:0];
    pixelY                = y[10:0];
    drawingRequestBorders = bord;
    drawingRequestBalls   = balls;
    hit.hitAck            = ack;
    model_step(sof, x, y, bord, balls, ack);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Asynchronous reset away from the clock edge; outputs must drop at once.
  task automatic do_rst();
    #2;
    resetN = 1'b0;
    startOfFrame = 1'b0; pixelX = '0; pixelY = '0;
    drawingRequestBorders = 1'b0; drawingRequestBalls = '0; hit.hitAck = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", int'(hit.hitValid), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_ball", int'(hit.hitBall), 0);
    chk("rst_side", int'(hit.hitSide), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  function automatic int rand_coord(input int lim);
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 10)) - 5;
      1:       return lim - 5 + int'($urandom_range(0, 10));
      default: return int'($urandom_range(0, 1000)) - 50;
    endcase
  endfunction

  initial begin
    resetN = 1'b0;
    hit.hitAck = 1'b0;
    startOfFrame = 1'b0; pixelX = '0; pixelY = '0;
    drawingRequestBorders = 1'b0; drawingRequestBalls = '0;
    do_rst();

    // Single top-wall hit by ball 2, presented the cycle after the boundary.
    cyc(0, 100, -1, 0, 8'h00, 0);
    cyc(0, 0, 0, 1, 8'b0000_0100, 0);
    cyc(1, 0, 0, 0, 8'h00, 0);
    chk("t1_valid", int'(hit.hitValid), 1);
    chk("t1_ball", int'(hit.hitBall), 2);
    chk("t1_side", int'(hit.hitSide), 0);
    cyc(0, 0, 0, 0, 8'h00, 1);
    chk("t1_done", int'(hit.hitValid), 0);

    // Corner goes to bottom; the later right-wall overlap of ball 5 is ignored.
    cyc(0, -1, 480, 0, 8'h00, 0);
    cyc(0, 640, 200, 1, 8'b0010_0000, 0);
    cyc(0, 0, 0, 1, 8'b0010_0000, 0);
    cyc(1, 0, 0, 0, 8'h00, 0);
    chk("t2_ball", int'(hit.hitBall), 5);
    chk("t2_side", int'(hit.hitSide), 1);
    cyc(0, 0, 0, 0, 8'h00, 1);
    chk("t2_single", int'(hit.hitValid), 0);

    // Back-to-back delivery with ack held: 0,3,7 from pointer 0.
    do_rst();
    cyc(0, 700, 100, 0, 8'h00, 0);
    cyc(0, 0, 0, 1, 8'b1000_1001, 0);
    cyc(1, 0, 0, 0, 8'h00, 1);
    chk("t3a_first", int'(hit.hitBall), 0);
    chk("t3a_side", int'(hit.hitSide), 3);
    cyc(0, 0, 0, 0, 8'h00, 1);
    chk("t3a_second", int'(hit.hitBall), 3);
    cyc(0, 0, 0, 0, 8'h00, 1);
    chk("t3a_third", int'(hit.hitBall), 7);
    cyc(0, 0, 0, 0, 8'h00, 1);
    chk("t3a_done", int'(hit.hitValid), 0);

    // Move the pointer to 4 by delivering ball 3, then expect 7,0,3.
    do_rst();
    cyc(0, 700, 100, 0, 8'h00, 0);
    cyc(0, 0, 0, 1, 8'b0000_1000, 0);
    cyc(1, 0, 0, 0, 8'h00, 0);
    cyc(0, 0, 0, 0, 8'h00, 1);
    cyc(0, -3, 300, 0, 8'h00, 0);
    cyc(0, 0, 0, 1, 8'b1000_1001, 0);
    cyc(1, 0, 0, 0, 8'h00, 1);
    chk("t3b_first", int'(hit.hitBall), 7);
    chk("t3b_side", int'(hit.hitSide), 2);
    cyc(0, 0, 0, 0, 8'h00, 1);
    chk("t3b_second", int'(hit.hitBall), 0);
    cyc(0, 0, 0, 0, 8'h00, 1);
    chk("t3b_third", int'(hit.hitBall), 3);
    cyc(0, 0, 0, 0, 8'h00, 1);
    chk("t3b_done", int'(hit.hitValid), 0);

    // Ball 4 left unacked at the next boundary is discarded with an overrun.
    do_rst();
    cyc(0, 50, 500, 0, 8'h00, 0);
    cyc(0, 0, 0, 1, 8'b0001_0010, 0);
    cyc(1, 0, 0, 0, 8'h00, 0);
    chk("t4_first", int'(hit.hitBall), 1);
    cyc(0, 0, 0, 0, 8'h00, 1);
    chk("t4_second", int'(hit.hitBall), 4);
    cyc(0, 0, 0, 0, 8'h00, 0);
    cyc(1, 0, 0, 0, 8'h00, 0);
    chk("t4_overrun", int'(overrun), 1);
    chk("t4_lost", int'(hit.hitValid), 0);
    cyc(0, 0, 0, 0, 8'h00, 0);
    chk("t4_pulse", int'(overrun), 0);

    // Ack on the boundary edge of the only pending report: no overrun.
    do_rst();
    cyc(0, 100, -1, 0, 8'h00, 0);
    cyc(0, 0, 0, 1, 8'b0100_0000, 0);
    cyc(1, 0, 0, 0, 8'h00, 0);
    cyc(0, 100, -1, 0, 8'h00, 0);
    cyc(0, 0, 0, 1, 8'b0000_0100, 0);
    cyc(1, 0, 0, 0, 8'h00, 1);
    chk("t5_overrun", int'(overrun), 0);
    chk("t5_valid", int'(hit.hitValid), 1);
    chk("t5_ball", int'(hit.hitBall), 2);

    // Reset while presenting and while overrun is high.
    do_rst();
    cyc(0, 100, -1, 0, 8'h00, 0);
    cyc(0, 0, 0, 1, 8'b0000_1010, 0);
    cyc(1, 0, 0, 0, 8'h00, 0);
    cyc(0, 100, -1, 0, 8'h00, 0);
    cyc(0, 0, 0, 1, 8'b0010_0000, 0);
    cyc(1, 0, 0, 0, 8'h00, 0);
    chk("t6_pre_overrun", int'(overrun), 1);
    chk("t6_pre_ball", int'(hit.hitBall), 5);
    do_rst();
    for (int f = 0; f < 2; f++) begin
      cyc(0, 0, 0, 0, 8'h00, 0);
      cyc(1, 0, 0, 0, 8'h00, 0);
      chk("t6_quiet", int'(hit.hitValid), 0);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_rst();
      end else begin
        cyc($urandom_range(0, 24) == 0, rand_coord(640), rand_coord(480),
            bit'($urandom_range(0, 1)), N'($urandom & $urandom & $urandom),
            $urandom_range(0, 2) != 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
